// File: rtl/axis_framer_pkg.sv
// Shared widths and skid-buffer occupancy encoding for the framer slice.
package axis_framer_pkg;

  localparam int unsigned DEF_DW    = 512;
  localparam int unsigned DEF_LEN_W = 16;
  localparam int unsigned DEF_CW    = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/axis_framer_if.sv
// AXI-stream bundle; slave_nolast is the upstream view that carries no tlast.
interface axis_framer_if
  import axis_framer_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
  modport slave_nolast (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer; upstream ready is a flop derived only from occupancy.
module axis_skid_buf
  import axis_framer_pkg::*;
#(
  parameter int unsigned W = DEF_DW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  occ_e         occ_q, occ_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q, rdy_d;
  logic         vld_q, vld_d;
  logic         acc, con;

  always_comb begin
    acc    = in_valid & rdy_q;
    con    = vld_q & out_ready;
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (acc) begin
          main_d = in_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && con) begin
          main_d = in_data;
        end else if (acc) begin
          skid_d = in_data;
          occ_d  = OCC_FULL;
        end else if (con) begin
          occ_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        // rdy_q is low here, so only a consume can happen
        if (con) begin
          main_d = skid_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    rdy_d = (occ_d != OCC_FULL);
    vld_d = (occ_d != OCC_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= rdy_d;
      vld_q  <= vld_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = main_q;
  assign out_valid = vld_q;

endmodule

// File: rtl/axis_framer.sv
// Cuts an untermed beat stream into frames of cfg_beats beats and counts frames.
module axis_framer
  import axis_framer_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned CW    = DEF_CW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LEN_W-1:0]         cfg_beats,
  axis_framer_if.slave_nolast      axis_in,
  axis_framer_if.master            axis_out,
  output logic [CW-1:0]            frame_count,
  output logic                     in_frame
);

  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cur_len;
  logic [CW-1:0]    frame_count_q, frame_count_d;
  logic             in_frame_q, in_frame_d;
  logic             in_ready;
  logic             in_last;
  logic             acc, con;
  logic [DW:0]      skid_out;

  // The buffer is a lossless FIFO, so the accept-order index equals the
  // consume-order index; tlast is fixed before the beat enters the buffer.
  always_comb begin
    acc        = axis_in.tvalid & in_ready;
    cur_len    = (beat_cnt_q == '0)
                 ? ((cfg_beats == '0) ? LEN_W'(1) : cfg_beats)
                 : len_q;
    in_last    = (beat_cnt_q == cur_len - LEN_W'(1));
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    if (acc) begin
      len_d      = cur_len;
      beat_cnt_d = in_last ? '0 : beat_cnt_q + LEN_W'(1);
    end
  end

  always_comb begin
    con           = axis_out.tvalid & axis_out.tready;
    frame_count_d = frame_count_q;
    in_frame_d    = in_frame_q;
    if (con) begin
      in_frame_d = ~axis_out.tlast;
      if (axis_out.tlast) frame_count_d = frame_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_q    <= '0;
      len_q         <= LEN_W'(1);
      frame_count_q <= '0;
      in_frame_q    <= 1'b0;
    end else begin
      beat_cnt_q    <= beat_cnt_d;
      len_q         <= len_d;
      frame_count_q <= frame_count_d;
      in_frame_q    <= in_frame_d;
    end
  end

  axis_skid_buf #(.W(DW + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({in_last, axis_in.tdata}),
    .in_valid  (axis_in.tvalid),
    .in_ready  (in_ready),
    .out_data  (skid_out),
    .out_valid (axis_out.tvalid),
    .out_ready (axis_out.tready)
  );

  assign axis_in.tready = in_ready;
  assign axis_out.tdata = skid_out[DW-1:0];
  assign axis_out.tlast = skid_out[DW];
  assign frame_count    = frame_count_q;
  assign in_frame       = in_frame_q;

endmodule

// File: tb/tb_axis_framer.sv
// Randomized and directed bench for axis_framer with a queue-based reference model.
module tb_axis_framer;
  import axis_framer_pkg::*;

  localparam int DW    = DEF_DW;
  localparam int LEN_W = DEF_LEN_W;
  localparam int CW    = DEF_CW;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [LEN_W-1:0] cfg_beats = LEN_W'(1);
  logic [CW-1:0]    frame_count;
  logic             in_frame;

  axis_framer_if #(.DW(DW)) in_if ();
  axis_framer_if #(.DW(DW)) out_if ();

  always #5 clk = ~clk;

  axis_framer #(.DW(DW), .LEN_W(LEN_W), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_beats   (cfg_beats),
    .axis_in     (in_if),
    .axis_out    (out_if),
    .frame_count (frame_count),
    .in_frame    (in_frame)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            m_idx = 0;
  int            m_len = 1;
  logic [CW-1:0] m_fc = '0;
  logic          m_inf = 1'b0;
  int            seg_cons = 0;
  int            seg_last_pos[$];
  int            cyc = 0;
  int            first_acc = -1;
  int            last_cons = -1;
  bit            rst_prev = 1'b0;
  bit            hold_p = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  bit            rnd_rdy = 1'b0;
  logic          fix_rdy = 1'b1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    out_if.tready = rnd_rdy ? logic'($urandom_range(0, 1)) : fix_rdy;
  end

  // Compare process: looks at the settled state before each edge and
  // applies the handshakes that edge will perform to the model.
  always @(negedge clk) begin
    beat_t e;
    bit    acc, con, last;
    cyc++;
    if (reset) begin
      if (rst_prev) begin
        chk("rst_tready", in_if.tready, 0);
        chk("rst_tvalid", out_if.tvalid, 0);
        chk("rst_tlast", out_if.tlast, 0);
        chk("rst_tdata", out_if.tdata, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_in_frame", in_frame, 0);
      end
      rst_prev = 1'b1;
      exp_q.delete();
      m_idx = 0; m_fc = '0; m_inf = 1'b0; hold_p = 1'b0;
    end else begin
      if (rst_prev) chk("post_rst_tready", in_if.tready, 0);
      else          chk("tready_vs_occ", in_if.tready, exp_q.size() < 2);
      rst_prev = 1'b0;
      chk("tvalid_vs_occ", out_if.tvalid, exp_q.size() > 0);
      chk("frame_count", frame_count, m_fc);
      chk("in_frame", in_frame, m_inf);
      if (hold_p) begin
        chk("stall_tdata", out_if.tdata, hold_d);
        chk("stall_tlast", out_if.tlast, hold_l);
      end
      acc = in_if.tvalid && in_if.tready;
      con = out_if.tvalid && out_if.tready;
      if (con) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", out_if.tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_tdata", out_if.tdata, e.data);
          chk("out_tlast", out_if.tlast, e.last);
        end
        seg_cons++;
        last_cons = cyc;
        if (out_if.tlast) begin
          seg_last_pos.push_back(seg_cons);
          m_fc++;
          m_inf = 1'b0;
        end else begin
          m_inf = 1'b1;
        end
      end
      if (acc) begin
        if (m_idx == 0) m_len = (cfg_beats == 0) ? 1 : int'(cfg_beats);
        last = (m_idx == m_len - 1);
        m_idx = last ? 0 : m_idx + 1;
        e.data = in_if.tdata;
        e.last = last;
        exp_q.push_back(e);
        if (first_acc < 0) first_acc = cyc;
      end
      hold_p = out_if.tvalid && !out_if.tready;
      hold_d = out_if.tdata;
      hold_l = out_if.tlast;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    int g = 0;
    bit a;
    in_if.tvalid = 1'b1;
    in_if.tdata  = d;
    do begin
      @(negedge clk);
      a = in_if.tready;
      @(posedge clk);
      #1;
      g++;
    end while (!a && g < 200);
    if (!a) chk("send_timeout", a, 1);
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      idle(1);
      g++;
    end
    chk("drain", exp_q.size(), 0);
    idle(2);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  task automatic seg_clear();
    seg_cons = 0;
    seg_last_pos.delete();
    first_acc = -1;
    last_cons = -1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #(10 * 120000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    out_if.tready = 1'b1;

    // Reset held 3 clocks with upstream valid asserted
    @(posedge clk); #1;
    in_if.tvalid = 1'b1;
    do_reset(3);
    in_if.tvalid = 1'b0;
    idle(1);
    @(negedge clk);
    chk("tready_after_release", in_if.tready, 1);
    chk("fc_after_release", frame_count, 0);
    idle(1);

    // Streaming, cfg 4, 12 beats
    seg_clear();
    cfg_beats = 4;
    fix_rdy = 1'b1;
    for (int i = 0; i < 12; i++) send(DW'(i));
    idle(3);
    chk("stream_fc", frame_count, 3);
    chk("stream_in_frame", in_frame, 0);
    chk("stream_nlast", seg_last_pos.size(), 3);
    if (seg_last_pos.size() == 3) begin
      chk("stream_last0", seg_last_pos[0], 4);
      chk("stream_last1", seg_last_pos[1], 8);
      chk("stream_last2", seg_last_pos[2], 12);
    end
    chk("stream_latency", last_cons - first_acc, 12);

    // Backpressure, cfg 3, 30 beats
    do_reset(1);
    seg_clear();
    cfg_beats = 3;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) send(rnd_data());
    drain();
    rnd_rdy = 1'b0;
    chk("bp_fc", frame_count, 10);
    chk("bp_cons", seg_cons, 30);

    // Config change mid-frame
    do_reset(1);
    seg_clear();
    cfg_beats = 5;
    for (int i = 0; i < 2; i++) send(DW'(100 + i));
    cfg_beats = 2;
    for (int i = 2; i < 9; i++) send(DW'(100 + i));
    drain();
    chk("cfg_fc", frame_count, 3);
    chk("cfg_nlast", seg_last_pos.size(), 3);
    if (seg_last_pos.size() == 3) begin
      chk("cfg_last0", seg_last_pos[0], 5);
      chk("cfg_last1", seg_last_pos[1], 7);
      chk("cfg_last2", seg_last_pos[2], 9);
    end

    // Edge lengths: 0, 1, then maximum
    do_reset(1);
    seg_clear();
    cfg_beats = 0;
    for (int i = 0; i < 5; i++) send(rnd_data());
    cfg_beats = 1;
    for (int i = 0; i < 5; i++) send(rnd_data());
    drain();
    chk("len01_nlast", seg_last_pos.size(), 10);
    seg_clear();
    cfg_beats = '1;
    for (int i = 0; i < 65535; i++) send(DW'(i));
    drain();
    chk("lenmax_nlast", seg_last_pos.size(), 1);
    if (seg_last_pos.size() == 1) chk("lenmax_pos", seg_last_pos[0], 65535);
    chk("lenmax_fc", frame_count, 11);
    chk("lenmax_in_frame", in_frame, 0);

    // Mid-frame reset with two beats stalled in the buffer
    do_reset(1);
    cfg_beats = 8;
    fix_rdy = 1'b1;
    for (int i = 0; i < 3; i++) send(DW'(200 + i));
    idle(1);
    fix_rdy = 1'b0;
    for (int i = 3; i < 5; i++) send(DW'(200 + i));
    @(negedge clk);
    chk("stalled_tvalid", out_if.tvalid, 1);
    chk("stalled_tready", in_if.tready, 0);
    idle(0);
    @(posedge clk); #1;
    do_reset(1);
    @(negedge clk);
    chk("mrst_tvalid", out_if.tvalid, 0);
    chk("mrst_fc", frame_count, 0);
    @(posedge clk); #1;
    seg_clear();
    fix_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(DW'(300 + i));
    drain();
    chk("mrst_nlast", seg_last_pos.size(), 1);
    if (seg_last_pos.size() == 1) chk("mrst_pos", seg_last_pos[0], 8);
    chk("mrst_fc_after", frame_count, 1);

    // Randomized traffic: cfg changes only when the pipeline is empty
    do_reset(1);
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cfg_beats = LEN_W'($urandom_range(0, 6));
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        send(rnd_data());
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();
    end
    rnd_rdy = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
